// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Control sequencer for the 6-bit program counter datapath. Conditions the
//   board buttons and switches and turns them into single-cycle load/count
//   pulses plus stable adder selects. It also provides an auto-run mode that
//   steps the PC every RUN_DIV cycles and halts before the PC would wrap.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive equal synchronized samples needed to change
//                     a debounced button value (>= 1)
//   RUN_DIV         : sysclk cycles between auto-steps in RUN (>= 2)
//
// Ports
//   sysclk     in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   BUTTONS    in   [3] load, [2] step, [1:0] N offset bits (raw)
//   SWITCHES   in   [0] run enable, [1] adder select (raw)
//   pc_value   in   current PC register value
//   ld         out  one-cycle load pulse (load enable + input mux select)
//   cnt        out  one-cycle count pulse
//   in_bit     out  MSB of the load value ({in_bit,5'b0})
//   add_mux_s  out  adder select, 0 = +4, 1 = +N
//   offset     out  N-adder bits, increment = {3'b0,offset,1'b0}
//   state      out  IDLE=0, STEP=1, RUN=2, HALT=3
module pc_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned RUN_DIV         = 8
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [3:0] BUTTONS,
    input  logic [1:0] SWITCHES,
    input  logic [5:0] pc_value,
    output logic       ld,
    output logic       cnt,
    output logic       in_bit,
    output logic       add_mux_s,
    output logic [1:0] offset,
    output logic [1:0] state
);

    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned DIV_W = $clog2(RUN_DIV);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    // Input conditioning state
    logic [3:0]            btn_s1_q, btn_s2_q;
    logic [1:0]            sw_s1_q, sw_s2_q;
    logic [1:0]            sync_vld_q;
    logic [3:0]            btn_db_q;
    logic [3:0][DB_W-1:0]  db_cnt_q;
    logic [1:0]            btn_prev_q;   // debounced {load, step} history
    logic [1:0]            armed_q;      // {load, step} seen released since reset

    // Sequencer state and registered outputs
    state_t                state_q;
    logic [DIV_W-1:0]      div_q;
    logic                  ld_q;
    logic                  cnt_q;
    logic                  in_bit_q;
    logic                  add_mux_s_q;
    logic [1:0]            offset_q;

    // Derived control
    logic                  load_evt;
    logic                  step_evt;
    logic                  run_en;
    logic                  tick;
    logic [6:0]            inc;
    logic [6:0]            sum;
    logic                  fits;
    logic                  cnt_d;

    // ------------------------------------------------------------------
    // Synchronizers, per-bit debounce and edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (reset) begin
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            sync_vld_q <= '0;
            btn_db_q   <= '0;
            db_cnt_q   <= '0;
            btn_prev_q <= '0;
            armed_q    <= '0;
        end else begin
            btn_s1_q   <= BUTTONS;
            btn_s2_q   <= btn_s1_q;
            sw_s1_q    <= SWITCHES;
            sw_s2_q    <= sw_s1_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};

            for (int unsigned i = 0; i < 4; i++) begin
                if (btn_s2_q[i] == btn_db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    btn_db_q[i] <= btn_s2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end

            btn_prev_q <= btn_db_q[3:2];

            // The synchronizer holds cleared values for two cycles after reset;
            // only a genuine released sample arms the edge detector, so a
            // button held through reset never fires until pressed again.
            if (sync_vld_q[1]) begin
                armed_q <= armed_q | ~btn_s2_q[3:2];
            end
        end
    end

    // ------------------------------------------------------------------
    // Event decode, halt check and count decision
    // ------------------------------------------------------------------
    always_comb begin
        load_evt = btn_db_q[3] & ~btn_prev_q[1] & armed_q[1];
        step_evt = btn_db_q[2] & ~btn_prev_q[0] & armed_q[0];
        run_en   = sw_s2_q[0];
        tick     = (div_q == DIV_LAST);

        inc  = add_mux_s_q ? {4'b0, offset_q, 1'b0} : 7'd4;
        sum  = {1'b0, pc_value} + inc;
        fits = (sum <= 7'd63);

        cnt_d = 1'b0;
        if (!load_evt) begin
            if (state_q == STEP) begin
                cnt_d = 1'b1;
            end else if (state_q == RUN && run_en && tick && fits) begin
                cnt_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Adder selects. Held both on the edge that raises cnt and while cnt is
    // high, so the pulse always carries the increment the halt check used.
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (reset) begin
            add_mux_s_q <= 1'b0;
            offset_q    <= '0;
        end else if (!cnt_q && !cnt_d) begin
            add_mux_s_q <= sw_s2_q[1];
            offset_q    <= btn_db_q[1:0];
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with registered pulse outputs
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            ld_q     <= 1'b0;
            cnt_q    <= 1'b0;
            in_bit_q <= 1'b0;
        end else begin
            ld_q     <= load_evt;
            cnt_q    <= cnt_d;
            in_bit_q <= 1'b1;

            unique case (state_q)
                IDLE: begin
                    if (run_en) begin
                        state_q <= RUN;
                        div_q   <= '0;
                    end else if (step_evt && !load_evt) begin
                        state_q <= STEP;
                    end
                end
                STEP: begin
                    state_q <= IDLE;
                end
                RUN: begin
                    if (!run_en) begin
                        state_q <= IDLE;
                        div_q   <= '0;
                    end else if (load_evt) begin
                        div_q <= '0;
                    end else if (tick) begin
                        div_q <= '0;
                        if (!fits) begin
                            state_q <= HALT;
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                HALT: begin
                    if (load_evt || !run_en) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ld        = ld_q;
    assign cnt       = cnt_q;
    assign in_bit    = in_bit_q;
    assign add_mux_s = add_mux_s_q;
    assign offset    = offset_q;
    assign state     = state_q;

endmodule
